// File: rtl/stream_src_p4_if.sv
// Read side of the kernel input ap_fifo lanes: data, not-empty flags and pop strobes.
// The source drives data and flags. The kernel drives the pop strobes.
interface stream_src_p4_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32
);
    logic [LANES*DATA_W-1:0] in_dout;
    logic [LANES-1:0]        in_empty_n;
    logic [LANES-1:0]        in_read;

    modport master (
        output in_dout,
        output in_empty_n,
        input  in_read
    );

    modport slave (
        input  in_dout,
        input  in_empty_n,
        output in_read
    );
endinterface

// File: rtl/stream_src_p4.sv
// Multi-lane ap_fifo stimulus source: each lane serves a fixed number of Galois-LFSR words
// to the kernel. Completion is reported by a sticky done flag and underflow by a sticky err flag.
module stream_src_p4 #(
    parameter int                LANES  = 4,
    parameter int                DATA_W = 32,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] SEED   = 32'h00000001,
    parameter logic [DATA_W-1:0] POLY   = 32'h80200003
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  words,
    stream_src_p4_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] lfsr_q [LANES];
    logic [DATA_W-1:0] lfsr_d [LANES];
    logic [CNT_W-1:0]  rem_q  [LANES];
    logic [CNT_W-1:0]  rem_d  [LANES];
    logic [LANES-1:0]  empty_n_q, empty_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [LANES-1:0]  pop;
    logic [LANES-1:0]  under;
    logic              all_drained;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
        return (v >> 1) ^ (v[0] ? POLY : '0);
    endfunction

    function automatic logic [DATA_W-1:0] lane_seed(input int lane);
        return SEED + DATA_W'(lane);
    endfunction

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        empty_n_d   = '0;
        all_drained = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            lfsr_d[i] = lfsr_q[i];
            rem_d[i]  = rem_q[i];
        end

        // A pop needs a visible word; any other read is an underflow and changes nothing else.
        pop   = bus.in_read & empty_n_q;
        under = bus.in_read & ~empty_n_q;
        err_d = err_q | (|under);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Clearing on start wins over a read landing on the same edge.
                    err_d  = 1'b0;
                    done_d = (words == '0);
                    for (int i = 0; i < LANES; i++) begin
                        lfsr_d[i] = lane_seed(i);
                        rem_d[i]  = words;
                    end
                    if (words != '0) begin
                        state_d   = RUN;
                        busy_d    = 1'b1;
                        empty_n_d = '1;
                    end
                end
            end
            RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    if (pop[i]) begin
                        rem_d[i]  = rem_q[i] - 1'b1;
                        lfsr_d[i] = lfsr_step(lfsr_q[i]);
                    end
                    if (rem_d[i] != '0) begin
                        empty_n_d[i] = 1'b1;
                        all_drained  = 1'b0;
                    end
                end
                if (all_drained) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            empty_n_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                lfsr_q[i] <= lane_seed(i);
                rem_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            empty_n_q <= empty_n_d;
            for (int i = 0; i < LANES; i++) begin
                lfsr_q[i] <= lfsr_d[i];
                rem_q[i]  <= rem_d[i];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_dout
        assign bus.in_dout[g*DATA_W +: DATA_W] = lfsr_q[g];
    end

    assign bus.in_empty_n = empty_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_stream_src_p4.sv
// Directed bench for stream_src_p4: a vector table for the basic single-run sequence,
// followed by hand-written multi-cycle sequences for drain, stall, underflow, start and reset cases.
module tb_stream_src_p4;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        start;
    logic [15:0] words;
    logic        busy, done, err;

    stream_src_p4_if #(.LANES(4), .DATA_W(32)) sif ();

    stream_src_p4 dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .start    (start),
        .words    (words),
        .bus      (sif),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        st;
        logic [15:0] wd;
        logic [3:0]  rd;
        logic [3:0]  e_en;
        logic [31:0] e_d0;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic [15:0] wd, input logic [3:0] rd);
        start       = st;
        words       = wd;
        sif.in_read = rd;
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [31:0] d0();
        return sif.in_dout[31:0];
    endfunction

    initial begin
        ap_rst_n    = 1'b0;
        start       = 1'b0;
        words       = '0;
        sif.in_read = '0;
        #12;
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);
        chk("rst_empty_n", {124'd0, sif.in_empty_n}, 128'd0);
        chk("rst_dout", sif.in_dout, {32'h4, 32'h3, 32'h2, 32'h1});
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // words=4, all lanes read continuously, lane 0 observed
        tbl[0] = '{1'b1, 16'd4, 4'b0000, 4'b1111, 32'h00000001, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'd0, 4'b1111, 4'b1111, 32'h80200003, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 16'd0, 4'b1111, 4'b1111, 32'hC0300002, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 16'd0, 4'b1111, 4'b1111, 32'h60180001, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'd0, 4'b1111, 4'b0000, 32'hB02C0003, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 16'd0, 4'b0000, 4'b0000, 32'hB02C0003, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            step(tbl[k].st, tbl[k].wd, tbl[k].rd);
            chk($sformatf("t1_empty_n[%0d]", k), {124'd0, sif.in_empty_n}, {124'd0, tbl[k].e_en});
            chk($sformatf("t1_dout0[%0d]", k), {96'd0, d0()}, {96'd0, tbl[k].e_d0});
            chk($sformatf("t1_busy[%0d]", k), {127'd0, busy}, {127'd0, tbl[k].e_busy});
            chk($sformatf("t1_done[%0d]", k), {127'd0, done}, {127'd0, tbl[k].e_done});
            chk($sformatf("t1_err[%0d]", k), {127'd0, err}, {127'd0, tbl[k].e_err});
        end

        // words=2, lanes 0-2 drain first, lane 3 lags
        step(1'b1, 16'd2, 4'b0000);
        chk("t2_dout_start", sif.in_dout, {32'h4, 32'h3, 32'h2, 32'h1});
        chk("t2_done_clr", {127'd0, done}, 128'd0);
        step(1'b0, 16'd0, 4'b0111);
        chk("t2_dout_pop1", sif.in_dout, {32'h4, 32'h80200002, 32'h1, 32'h80200003});
        step(1'b0, 16'd0, 4'b0111);
        chk("t2_empty_n_lag", {124'd0, sif.in_empty_n}, {124'd0, 4'b1000});
        chk("t2_busy_lag", {127'd0, busy}, 128'd1);
        chk("t2_done_lag", {127'd0, done}, 128'd0);
        step(1'b0, 16'd0, 4'b1000);
        chk("t2_lane3_w1", {96'd0, sif.in_dout[127:96]}, {96'd0, 32'h2});
        chk("t2_done_mid", {127'd0, done}, 128'd0);
        step(1'b0, 16'd0, 4'b1000);
        chk("t2_done_end", {127'd0, done}, 128'd1);
        chk("t2_busy_end", {127'd0, busy}, 128'd0);
        chk("t2_err_end", {127'd0, err}, 128'd0);

        // words=3, lane 0 reads with stalls, others idle
        step(1'b1, 16'd3, 4'b0000);
        step(1'b0, 16'd0, 4'b0001);
        step(1'b0, 16'd0, 4'b0000);
        chk("t3_stall_hold", {96'd0, d0()}, {96'd0, 32'h80200003});
        step(1'b0, 16'd0, 4'b0001);
        step(1'b0, 16'd0, 4'b0000);
        step(1'b0, 16'd0, 4'b0001);
        chk("t3_empty_n", {124'd0, sif.in_empty_n}, {124'd0, 4'b1110});
        chk("t3_dout0", {96'd0, d0()}, {96'd0, 32'h60180001});
        chk("t3_busy", {127'd0, busy}, 128'd1);
        chk("t3_done", {127'd0, done}, 128'd0);
        chk("t3_err", {127'd0, err}, 128'd0);
        step(1'b0, 16'd0, 4'b1110);
        step(1'b0, 16'd0, 4'b1110);
        chk("t3_done_pre", {127'd0, done}, 128'd0);
        step(1'b0, 16'd0, 4'b1110);
        chk("t3_done_end", {127'd0, done}, 128'd1);
        chk("t3_busy_end", {127'd0, busy}, 128'd0);

        // underflow handling
        step(1'b0, 16'd0, 4'b0001);
        chk("t4_idle_under", {127'd0, err}, 128'd1);
        step(1'b0, 16'd0, 4'b0000);
        chk("t4_err_sticky", {127'd0, err}, 128'd1);
        step(1'b1, 16'd1, 4'b0001);
        chk("t4_start_clr", {127'd0, err}, 128'd0);
        chk("t4_start_en", {124'd0, sif.in_empty_n}, {124'd0, 4'b1111});
        step(1'b0, 16'd0, 4'b0001);
        chk("t4_pop_err", {127'd0, err}, 128'd0);
        chk("t4_pop_dout0", {96'd0, d0()}, {96'd0, 32'h80200003});
        step(1'b0, 16'd0, 4'b0001);
        chk("t4_under_err", {127'd0, err}, 128'd1);
        chk("t4_under_dout0", {96'd0, d0()}, {96'd0, 32'h80200003});
        chk("t4_under_en", {124'd0, sif.in_empty_n}, {124'd0, 4'b1110});
        step(1'b0, 16'd0, 4'b1110);
        chk("t4_done", {127'd0, done}, 128'd1);
        chk("t4_err_keep", {127'd0, err}, 128'd1);

        // start while running is ignored
        step(1'b1, 16'd3, 4'b0000);
        step(1'b0, 16'd0, 4'b1111);
        step(1'b1, 16'd9, 4'b0000);
        chk("t5_ign_dout0", {96'd0, d0()}, {96'd0, 32'h80200003});
        chk("t5_ign_busy", {127'd0, busy}, 128'd1);
        step(1'b0, 16'd0, 4'b1111);
        chk("t5_seq_dout0", {96'd0, d0()}, {96'd0, 32'hC0300002});
        step(1'b0, 16'd0, 4'b1111);
        chk("t5_done", {127'd0, done}, 128'd1);
        chk("t5_busy", {127'd0, busy}, 128'd0);

        // asynchronous reset in the middle of a long run
        step(1'b1, 16'd100, 4'b0000);
        for (int k = 0; k < 10; k++) step(1'b0, 16'd0, 4'b1111);
        chk("t6_busy_run", {127'd0, busy}, 128'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {127'd0, busy}, 128'd0);
        chk("t6_rst_en", {124'd0, sif.in_empty_n}, 128'd0);
        chk("t6_rst_dout", sif.in_dout, {32'h4, 32'h3, 32'h2, 32'h1});
        sif.in_read = '0;
        #2 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        step(1'b1, 16'd100, 4'b0000);
        chk("t6_replay0", {96'd0, d0()}, {96'd0, 32'h00000001});
        step(1'b0, 16'd0, 4'b0001);
        chk("t6_replay1", {96'd0, d0()}, {96'd0, 32'h80200003});
        step(1'b0, 16'd0, 4'b0001);
        chk("t6_replay2", {96'd0, d0()}, {96'd0, 32'hC0300002});

        // start with zero words straight after reset
        #2 ap_rst_n = 1'b0;
        #2 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("t7_done_pre", {127'd0, done}, 128'd0);
        step(1'b1, 16'd0, 4'b0000);
        chk("t7_done", {127'd0, done}, 128'd1);
        chk("t7_busy", {127'd0, busy}, 128'd0);
        chk("t7_en", {124'd0, sif.in_empty_n}, 128'd0);
        step(1'b0, 16'd0, 4'b0000);
        chk("t7_done_hold", {127'd0, done}, 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
